// File: rtl/envio_pkg.sv
// Shared definitions for the response transmitter: FSM states, UART frame
// constants and the response codes exchanged with the host.
// Optional feature macro: ENVIO_PARITY_EN (adds an even-parity bit per byte).
package envio_pkg;

`ifdef ENVIO_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;
`endif

  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

  // Response codes understood by the host side
  localparam logic [7:0] RESP_07 = 8'h07;
  localparam logic [7:0] RESP_08 = 8'h08;
  localparam logic [7:0] RESP_09 = 8'h09;
  localparam logic [7:0] RESP_0A = 8'h0A;
  localparam logic [7:0] RESP_0B = 8'h0B;
  localparam logic [7:0] RESP_0D = 8'h0D;
  localparam logic [7:0] RESP_0E = 8'h0E;
  localparam logic [7:0] RESP_1F = 8'h1F;
  localparam logic [7:0] RESP_45 = 8'h45;
  localparam logic [7:0] RESP_FF = 8'hFF;
  localparam logic [7:0] RESP_AB = 8'hAB;

  // Even parity: XOR of all data bits
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/envio_resposta_baud_tick.sv
// Bit-time generator: one-cycle tick every CLKS_PER_BIT cycles, restarted
// from zero by clr_i so the first bit of a frame gets a full bit time.
module baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Next count: clear on request, otherwise wrap at the last cycle of a bit
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/envio_resposta.sv
// Sends a two-byte response (command, then value) over a UART line when the
// sensor stage raises its data-ready level.
// Optional feature macro: ENVIO_PARITY_EN (even parity bit after each byte).
module envio_resposta
  import envio_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] response_command,
  input  logic [7:0] response_value,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

  state_t     state_q;
  logic       send_prev_q;
  logic [7:0] cmd_q, val_q;
  logic       byte_sel_q;
  logic [2:0] bit_idx_q;
  logic       tx_q, busy_q, done_q;
  logic       tick, trigger;
  logic [7:0] cur_byte;

  // Done cycle is still IDLE, so it is excluded explicitly
  assign trigger  = send && !send_prev_q && (state_q == ST_IDLE) && !done_q;
  assign cur_byte = byte_sel_q ? val_q : cmd_q;

  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (trigger),
    .tick_o (tick)
  );

  // Frame FSM with registered line and status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      send_prev_q <= 1'b1;
      cmd_q       <= '0;
      val_q       <= '0;
      byte_sel_q  <= 1'b0;
      bit_idx_q   <= '0;
      tx_q        <= STOP_BIT;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      send_prev_q <= send;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            cmd_q      <= response_command;
            val_q      <= response_value;
            byte_sel_q <= 1'b0;
            bit_idx_q  <= '0;
            tx_q       <= START_BIT;
            busy_q     <= 1'b1;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx_q    <= cur_byte[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef ENVIO_PARITY_EN
              tx_q    <= even_parity(cur_byte);
              state_q <= ST_PARITY;
`else
              tx_q    <= STOP_BIT;
              state_q <= ST_STOP;
`endif
            end else begin
              tx_q      <= cur_byte[bit_idx_q + 3'd1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
`ifdef ENVIO_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            tx_q    <= STOP_BIT;
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            bit_idx_q <= '0;
            if (!byte_sel_q) begin
              byte_sel_q <= 1'b1;
              tx_q       <= START_BIT;
              state_q    <= ST_START;
            end else begin
              byte_sel_q <= 1'b0;
              tx_q       <= STOP_BIT;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_envio_resposta.sv
// Scoreboard bench for envio_resposta at CLKS_PER_BIT = 10.
module tb_envio_resposta;
  import envio_pkg::*;

  localparam int CPB  = 10;
  localparam int HALF = 5;
`ifdef ENVIO_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAT = 1 + 2 * NB * CPB;

  logic       clk, rst, send;
  logic [7:0] cmd, val;
  logic       tx, busy, done;

  envio_resposta #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clock            (clk),
    .reset            (rst),
    .send             (send),
    .response_command (cmd),
    .response_value   (val),
    .tx               (tx),
    .busy             (busy),
    .done             (done)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int trig;

  logic [7:0] exp_q[$];
  int         dq[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Serial decoder: samples tx mid-bit and checks each byte against the queue
  int         m_cnt = 0;
  bit         m_act = 0;
  logic [7:0] m_byte;
  logic       m_par;
  logic [7:0] e;
  always @(negedge clk) begin
    int idx;
    if (rst) m_act = 0;
    else if (!m_act) begin
      if (tx === 1'b0) begin
        m_act = 1;
        m_cnt = 1;
      end
    end else m_cnt = m_cnt + 1;
    if (m_act && !rst && (m_cnt % CPB) == HALF) begin
      idx = m_cnt / CPB;
      if (idx == 0) chk("start_bit", 32'(tx), 32'(START_BIT));
      else if (idx <= 8) m_byte[idx-1] = tx;
      else if (idx < NB - 1) m_par = tx;
      if (idx == NB - 1) begin
        chk("stop_bit", 32'(tx), 32'(STOP_BIT));
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", m_byte);
        end else begin
          e = exp_q.pop_front();
          chk("rx_byte", 32'(m_byte), 32'(e));
`ifdef ENVIO_PARITY_EN
          chk("parity_bit", 32'(m_par), 32'(^e));
`endif
        end
        m_act = 0;
      end
    end
  end

  // Done monitor: latency from the recorded trigger cycle
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (dq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
      end else chk("done_latency", 32'(cyc - dq.pop_front()), 32'(LAT));
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic start_frame(input logic [7:0] c, input logic [7:0] v);
    cmd  = c;
    val  = v;
    send = 1'b1;
    trig = cyc;
    exp_q.push_back(c);
    exp_q.push_back(v);
    dq.push_back(trig);
  endtask

  task automatic drained(input string nm);
    chk({nm, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_done_left"}, 32'(dq.size()), 32'd0);
  endtask

  // Plain frame: trigger, release send, then check the end of frame
  task automatic run_frame(input logic [7:0] c, input logic [7:0] v);
    start_frame(c, v);
    wait_to(trig + 2);
    send = 1'b0;
    wait_to(trig + LAT + 3);
    drained("frame");
  endtask

  initial begin
    rst  = 1'b1;
    send = 1'b1;
    cmd  = 8'h00;
    val  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // send already high at reset release must not trigger
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("no_trig_after_reset", 32'(busy), 32'd0);
    send = 1'b0;
    @(negedge clk);

    // Basic frame with busy/done timing; inputs change after trigger
    start_frame(RESP_09, 8'h1A);
    wait_to(trig + 1);
    chk("busy_first", 32'(busy), 32'd1);
    chk("tx_start", 32'(tx), 32'd0);
    wait_to(trig + 2);
    send = 1'b0;
    cmd  = 8'h00;
    val  = 8'h00;
    wait_to(trig + LAT - 1);
    chk("busy_last", 32'(busy), 32'd1);
    wait_to(trig + LAT);
    chk("busy_drop", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    wait_to(trig + LAT + 1);
    chk("done_one_cycle", 32'(done), 32'd0);
    drained("basic");

    // send held high: exactly one transmission
    start_frame(RESP_45, RESP_45);
    wait_to(trig + 500);
    chk("held_idle", 32'(busy), 32'd0);
    drained("held");
    send = 1'b0;
    @(negedge clk);

    // Second edge mid-frame with new bytes is ignored
    start_frame(RESP_1F, RESP_0D);
    wait_to(trig + 10);
    send = 1'b0;
    wait_to(trig + 50);
    send = 1'b1;
    cmd  = RESP_FF;
    val  = RESP_FF;
    wait_to(trig + 60);
    send = 1'b0;
    wait_to(trig + LAT + 3);
    drained("midframe");

    // Reset mid-frame aborts without done
    start_frame(RESP_0B, RESP_AB);
    wait_to(trig + 5);
    send = 1'b0;
    wait_to(trig + 75);
    rst = 1'b1;
    exp_q.delete();
    dq.delete();
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (250) @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    run_frame(RESP_AB, RESP_0E);

    // Trigger in the done cycle is ignored
    start_frame(RESP_0A, RESP_1F);
    wait_to(trig + 2);
    send = 1'b0;
    wait_to(trig + LAT);
    chk("done_cycle_done", 32'(done), 32'd1);
    send = 1'b1;
    wait_to(trig + LAT + 3);
    chk("done_cycle_ignored", 32'(busy), 32'd0);
    send = 1'b0;
    @(negedge clk);
    drained("donecycle");

    // Parity reference vector and all-ones/all-zeros boundaries
    run_frame(RESP_07, RESP_08);
    run_frame(RESP_FF, 8'h00);
    run_frame(8'h00, RESP_FF);

    repeat (20) @(negedge clk);
    chk("final_idle_tx", 32'(tx), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
